// File: rtl/ysyx_040729_exe_div_ctrl.sv
// Sequencing control around an unsigned iterative divider: operand conditioning, special-case
// bypass (divide by zero, signed overflow) and sign correction of the returned result.
module ysyx_040729_exe_div_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            dv_valid,
    input  logic            dv_ready,
    output logic            dv_divw,
    output logic [XLEN-1:0] dv_dividend,
    output logic [XLEN-1:0] dv_divisor,
    output logic            dv_flush,
    input  logic            dv_out_valid,
    input  logic [XLEN-1:0] dv_quotient,
    input  logic [XLEN-1:0] dv_remainder
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic            rem_q, rem_d;
    logic            word_q, word_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    // Word results always take bit 31 as the sign, whatever the op.
    function automatic logic [XLEN-1:0] fit(input logic word, input logic [XLEN-1:0] v);
        return word ? sext32(v[31:0]) : v;
    endfunction

    logic            in_signed;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, bypass_res;
    logic            a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] raw, corr;

    always_comb begin
        in_signed = ~req_op[0];
        if (req_word) begin
            a_ext = in_signed ? sext32(req_src1[31:0]) : zext32(req_src1[31:0]);
            b_ext = in_signed ? sext32(req_src2[31:0]) : zext32(req_src2[31:0]);
            min_val = sext32(32'h8000_0000);
        end else begin
            a_ext = req_src1;
            b_ext = req_src2;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg = in_signed & a_ext[XLEN-1];
        b_neg = in_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        overflow = in_signed & (a_ext == min_val) & (b_ext == '1);
        if (div_zero) begin
            bypass_res = req_op[1] ? a_ext : '1;
        end else begin
            bypass_res = req_op[1] ? '0 : a_ext;
        end
    end

    always_comb begin
        raw  = rem_q ? dv_remainder : dv_quotient;
        corr = (rem_q ? r_neg_q : q_neg_q) ? -raw : raw;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        word_d   = word_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && !flush) begin
                    rem_d   = req_op[1];
                    word_d  = req_word;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    if (div_zero || overflow) begin
                        result_d = fit(req_word, bypass_res);
                        state_d  = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (dv_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (dv_out_valid) begin
                    result_d = fit(word_q, corr);
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (flush || resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            rem_q    <= 1'b0;
            word_q   <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            word_q   <= word_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        req_ready   = (state_q == StIdle);
        dv_valid    = (state_q == StIssue);
        dv_flush    = flush & ((state_q == StIssue) | (state_q == StWait));
        resp_valid  = (state_q == StResp);
        resp_result = result_q;
        dv_divw     = 1'b0;
        dv_dividend = dvd_q;
        dv_divisor  = dvs_q;
    end

endmodule

// File: tb/tb_ysyx_040729_exe_div_ctrl.sv
// Bench for the divider controller: table vectors, random ops against an arithmetic model,
// and hand sequences for flush / reset corners.
module tb_ysyx_040729_exe_div_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_word, flush;
    logic [1:0]  req_op;
    logic [63:0] req_src1, req_src2;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_result;
    logic        dv_valid, dv_ready, dv_divw, dv_flush, dv_out_valid;
    logic [63:0] dv_dividend, dv_divisor, dv_quotient, dv_remainder;

    int errors = 0;
    int checks = 0;

    ysyx_040729_exe_div_ctrl #(.XLEN(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_word     (req_word),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .dv_valid     (dv_valid),
        .dv_ready     (dv_ready),
        .dv_divw      (dv_divw),
        .dv_dividend  (dv_dividend),
        .dv_divisor   (dv_divisor),
        .dv_flush     (dv_flush),
        .dv_out_valid (dv_out_valid),
        .dv_quotient  (dv_quotient),
        .dv_remainder (dv_remainder)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result straight from the ISA division rules.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        int sa, sb;
        int unsigned ua, ub;
        longint la, lb;
        longint unsigned lua, lub;
        logic [31:0] r32;
        logic [63:0] r64;
        if (word) begin
            sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
            if (b[31:0] == 32'h0) r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF;
            else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                r32 = op[1] ? 32'h0 : 32'h8000_0000;
            else begin
                case (op)
                    2'b00:   r32 = sa / sb;
                    2'b01:   r32 = ua / ub;
                    2'b10:   r32 = sa % sb;
                    default: r32 = ua % ub;
                endcase
            end
            return {{32{r32[31]}}, r32};
        end
        la = a; lb = b; lua = a; lub = b;
        if (b == 64'h0) r64 = op[1] ? a : '1;
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) r64 = op[1] ? 64'h0 : a;
        else begin
            case (op)
                2'b00:   r64 = la / lb;
                2'b01:   r64 = lua / lub;
                2'b10:   r64 = la % lb;
                default: r64 = lua % lub;
            endcase
        end
        return r64;
    endfunction

    function automatic logic is_bypass(input logic [1:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
        if (word)
            return (b[31:0] == 32'h0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'h0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Absolute value of the operand as the op interprets it.
    function automatic logic [63:0] magnitude(input logic [1:0] op, input logic word,
                                              input logic [63:0] v);
        longint s;
        if (word) s = op[0] ? longint'({32'h0, v[31:0]}) : longint'(signed'(v[31:0]));
        else s = v;
        if (!op[0] && s < 0) return 64'(-s);
        return 64'(s);
    endfunction

    task automatic do_op(input string name, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int dv_stall, input int dv_lat, input int resp_stall);
        logic [63:0] ma, mb;
        ma = magnitude(op, word, a);
        mb = magnitude(op, word, b);
        req_valid = 1'b1; req_op = op; req_word = word; req_src1 = a; req_src2 = b;
        check({name, " req_ready"}, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        if (is_bypass(op, word, a, b)) begin
            check({name, " bypass resp_valid"}, 64'(resp_valid), 64'd1);
            check({name, " bypass dv_valid"}, 64'(dv_valid), 64'd0);
        end else begin
            check({name, " dv_valid"}, 64'(dv_valid), 64'd1);
            check({name, " dv_dividend"}, dv_dividend, ma);
            check({name, " dv_divisor"}, dv_divisor, mb);
            check({name, " dv_divw"}, 64'(dv_divw), 64'd0);
            for (int i = 0; i < dv_stall; i++) begin
                tick();
                check({name, " dv_valid hold"}, 64'(dv_valid), 64'd1);
            end
            dv_ready = 1'b1;
            tick();
            dv_ready = 1'b0;
            check({name, " wait dv_valid"}, 64'(dv_valid), 64'd0);
            for (int i = 0; i < dv_lat; i++) tick();
            check({name, " wait resp_valid"}, 64'(resp_valid), 64'd0);
            dv_out_valid = 1'b1; dv_quotient = ma / mb; dv_remainder = ma % mb;
            tick();
            dv_out_valid = 1'b0;
            check({name, " resp_valid"}, 64'(resp_valid), 64'd1);
        end
        for (int i = 0; i < resp_stall; i++) begin
            tick();
            check({name, " resp_valid hold"}, 64'(resp_valid), 64'd1);
            check({name, " result hold"}, resp_result, exp);
        end
        resp_ready = 1'b1;
        check({name, " resp_result"}, resp_result, exp);
        check({name, " req_ready in resp"}, 64'(req_ready), 64'd0);
        tick();
        resp_ready = 1'b0;
        check({name, " resp_valid drop"}, 64'(resp_valid), 64'd0);
        check({name, " idle req_ready"}, 64'(req_ready), 64'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          dv_stall;
        int          resp_stall;
    } vec_t;

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 64'h0;
            1:       return 64'($urandom_range(0, 20));
            2:       return -64'($urandom_range(1, 20));
            3:       return 64'h8000_0000_0000_0000;
            4:       return '1;
            5:       return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        vec_t vecs[11];
        logic [63:0] a, b;
        logic [1:0] op;
        logic word;

        vecs[0]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0};
        vecs[1]  = '{2'b10, 1'b1, 64'h0000_0000_8000_0007, 64'd0, 64'hFFFF_FFFF_8000_0007, 0, 1};
        vecs[2]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 0};
        vecs[3]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 0, 0};
        vecs[4]  = '{2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 3, 2};
        vecs[5]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 1, 0};
        vecs[6]  = '{2'b01, 1'b0, 64'd1234, 64'd0, '1, 0, 0};
        vecs[7]  = '{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 0, 0};
        vecs[8]  = '{2'b11, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 0, 0};
        vecs[9]  = '{2'b01, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'h1, '1, 2, 1};
        vecs[10] = '{2'b10, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, 0};

        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_word = 1'b0;
        req_src1 = '0; req_src2 = '0; flush = 1'b0; resp_ready = 1'b0;
        dv_ready = 1'b0; dv_out_valid = 1'b0; dv_quotient = '0; dv_remainder = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset resp_result", resp_result, 64'd0);
        check("reset dv_valid", 64'(dv_valid), 64'd0);
        check("reset dv_flush", 64'(dv_flush), 64'd0);
        check("reset dv_dividend", dv_dividend, 64'd0);
        check("reset dv_divisor", dv_divisor, 64'd0);
        check("reset dv_divw", 64'(dv_divw), 64'd0);

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].dv_stall, 2, vecs[i].resp_stall);

        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            word = 1'($urandom_range(0, 1));
            a = rnd_operand();
            b = rnd_operand();
            do_op($sformatf("rnd%0d", n), op, word, a, b, ref_result(op, word, a, b),
                  $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2));
        end

        // Stray divider result while idle must not produce a response.
        dv_out_valid = 1'b1;
        tick();
        dv_out_valid = 1'b0;
        check("stray out_valid resp_valid", 64'(resp_valid), 64'd0);

        // Flush in WAIT, followed by a late divider result.
        req_valid = 1'b1; req_op = 2'b00; req_word = 1'b0; req_src1 = 64'd50; req_src2 = 64'd3;
        dv_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        dv_ready = 1'b0;
        flush = 1'b1;
        #1;
        check("wait flush dv_flush", 64'(dv_flush), 64'd1);
        tick();
        flush = 1'b0;
        #1;
        check("wait flush pulse end", 64'(dv_flush), 64'd0);
        check("wait flush idle", 64'(req_ready), 64'd1);
        check("wait flush no resp", 64'(resp_valid), 64'd0);
        dv_out_valid = 1'b1; dv_quotient = 64'd16; dv_remainder = 64'd2;
        tick();
        dv_out_valid = 1'b0;
        check("late out_valid ignored", 64'(resp_valid), 64'd0);

        // Flush in ISSUE.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("issue flush dv_flush", 64'(dv_flush), 64'd1);
        tick();
        flush = 1'b0;
        check("issue flush idle", 64'(req_ready), 64'd1);
        check("issue flush dv_valid", 64'(dv_valid), 64'd0);

        // Flush concurrent with a request blocks acceptance.
        req_valid = 1'b1; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("idle flush blocks dv_valid", 64'(dv_valid), 64'd0);
        check("idle flush blocks req_ready", 64'(req_ready), 64'd1);

        // Flush in RESP drops the result.
        req_valid = 1'b1; req_src2 = 64'd0;
        tick();
        req_valid = 1'b0;
        check("resp flush pre", 64'(resp_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("resp flush drop", 64'(resp_valid), 64'd0);

        // Reset in RESP while the consumer stalls.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("resp reset pre", 64'(resp_valid), 64'd1);
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        check("resp reset resp_valid", 64'(resp_valid), 64'd0);
        check("resp reset req_ready", 64'(req_ready), 64'd1);
        check("resp reset result", resp_result, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
